decode_stage: RTL

//  Registered RV32I instruction decode stage; the producer of the 4-bit ALU opcode and operand selects

---
 rtl/decode_pkg.sv | 91 +++++++++
 rtl/imm_gen.sv | 45 ++++
 rtl/decode_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I decode stage and the execute-stage ALU:
//   alu_op_e        4-bit ALU opcode consumed by execute
//   opa_sel_e       operand-A source select (rs1 / pc / zero)
//   opb_sel_e       operand-B source select (rs2 / imm)
//   imm_fmt_e       immediate format selected by imm_gen
//   decode_bundle_t registered bundle handed from decode to execute
//   OPC_*           RV32I major opcodes
//   alu_op_from_funct3  funct3 (+ alternate bit) -> ALU opcode
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam int XLEN_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } opb_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        alu_op_e             alu_op;
        opa_sel_e            opa_sel;
        opb_sel_e            opb_sel;
        logic [XLEN_W-1:0]   imm;
        logic [REG_AW-1:0]   rs1_addr;
        logic [REG_AW-1:0]   rs2_addr;
        logic [REG_AW-1:0]   rd_addr;
        logic                rd_wren;
        logic                mem_rden;
        logic                mem_wren;
        logic                br_en;
        logic                jmp_en;
    } decode_bundle_t;

    // The alternate bit picks SUB over ADD and SRA over SRL; callers decide
    // whether instr[30] is meaningful for the instruction class.
    function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3,
                                                   input logic       alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// ----------------------------------------------------------------------------
// imm_gen
// Combinational RV32I immediate generator. The format is chosen from the
// major opcode, then the instruction bits are scattered and sign-extended.
// Formats without an immediate (R-type, unknown opcodes) produce zero.
// Ports:
//   instr  in  32  instruction word
//   imm    out 32  sign-extended immediate (I/S/B/U/J)
// ----------------------------------------------------------------------------
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    // Map the major opcode to the immediate format it uses.
    always_comb begin
        fmt = IMM_NONE;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
    end

    // Assemble the immediate; B and J offsets are halfword-aligned so bit 0 is zero.
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Registered RV32I decode stage between fetch and execute. One instruction is
// decoded per accepted valid/ready handshake; the bundle is held while execute
// stalls and i_flush kills both the held and the incoming instruction.
// Optional feature macro: DECODE_ILLEGAL_CHK_EN adds o_illegal, registered with
// the bundle; when undefined, unknown encodings decode as a NOP.
// Ports:
//   i_clk, i_rst_n             clock (rising edge), async active-low reset
//   i_valid / o_ready          fetch handshake carrying i_instr / i_pc
//   i_flush                    branch redirect, drops held and incoming instr
//   o_valid / i_ready          execute handshake for the decoded bundle
//   o_pc                       registered pc
//   o_alu_op                   ALU opcode (decode_pkg::alu_op_e)
//   o_opa_sel / o_opb_sel      operand selects
//   o_imm                      sign-extended immediate
//   o_rs1_addr/o_rs2_addr/o_rd_addr  register addresses
//   o_rd_wren                  writeback enable (never for x0)
//   o_mem_rden / o_mem_wren    load / store
//   o_br_en / o_jmp_en         conditional branch / JAL-JALR
//   o_illegal                  illegal encoding (only with DECODE_ILLEGAL_CHK_EN)
// ----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_pc,
    output logic [3:0]       o_alu_op,
    output logic [1:0]       o_opa_sel,
    output logic             o_opb_sel,
    output logic [XLEN-1:0]  o_imm,
    output logic [RF_AW-1:0] o_rs1_addr,
    output logic [RF_AW-1:0] o_rs2_addr,
    output logic [RF_AW-1:0] o_rd_addr,
    output logic             o_rd_wren,
    output logic             o_mem_rden,
    output logic             o_mem_wren,
    output logic             o_br_en,
`ifdef DECODE_ILLEGAL_CHK_EN
    output logic             o_illegal,
`endif
    output logic             o_jmp_en
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic              accept;
    decode_bundle_t    dec;
    decode_bundle_t    bundle_q;
    logic [XLEN-1:0]   pc_q;
    logic              valid_q;
`ifdef DECODE_ILLEGAL_CHK_EN
    logic [6:0]        funct7;
    logic              illegal;
    logic              illegal_q;
`endif

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
`ifdef DECODE_ILLEGAL_CHK_EN
    assign funct7 = i_instr[31:25];
`endif

    imm_gen u_imm_gen (
        .instr (i_instr),
        .imm   (imm)
    );

    // Decode the incoming word into a bundle. Defaults describe a NOP
    // (ADD rs1, rs2 with every enable low) so unknown opcodes fall out as one.
    always_comb begin
        dec          = '0;
        dec.alu_op   = ALU_ADD;
        dec.opa_sel  = OPA_RS1;
        dec.opb_sel  = OPB_RS2;
        dec.imm      = imm;
        dec.rs1_addr = i_instr[19:15];
        dec.rs2_addr = i_instr[24:20];
        dec.rd_addr  = i_instr[11:7];
`ifdef DECODE_ILLEGAL_CHK_EN
        illegal      = 1'b0;
`endif
        case (opcode)
            OPC_OP: begin
                dec.alu_op  = alu_op_from_funct3(funct3, i_instr[30]);
                dec.rd_wren = 1'b1;
`ifdef DECODE_ILLEGAL_CHK_EN
                if (funct7 != 7'h00 && funct7 != 7'h20)
                    illegal = 1'b1;
                if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
                    illegal = 1'b1;
`endif
            end
            OPC_OP_IMM: begin
                // instr[30] is part of the immediate for ADDI etc.; it only
                // selects the arithmetic shift for SRLI/SRAI.
                dec.alu_op  = alu_op_from_funct3(funct3, i_instr[30] && (funct3 == 3'b101));
                dec.opb_sel = OPB_IMM;
                dec.rd_wren = 1'b1;
`ifdef DECODE_ILLEGAL_CHK_EN
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
                    illegal = 1'b1;
`endif
            end
            OPC_LOAD: begin
                dec.opb_sel  = OPB_IMM;
                dec.rd_wren  = 1'b1;
                dec.mem_rden = 1'b1;
            end
            OPC_STORE: begin
                dec.opb_sel  = OPB_IMM;
                dec.mem_wren = 1'b1;
            end
            OPC_BRANCH: begin
                dec.opa_sel = OPA_PC;
                dec.opb_sel = OPB_IMM;
                dec.br_en   = 1'b1;
            end
            OPC_LUI: begin
                dec.opa_sel = OPA_ZERO;
                dec.opb_sel = OPB_IMM;
                dec.rd_wren = 1'b1;
            end
            OPC_AUIPC: begin
                dec.opa_sel = OPA_PC;
                dec.opb_sel = OPB_IMM;
                dec.rd_wren = 1'b1;
            end
            OPC_JAL: begin
                dec.opa_sel = OPA_PC;
                dec.opb_sel = OPB_IMM;
                dec.rd_wren = 1'b1;
                dec.jmp_en  = 1'b1;
            end
            OPC_JALR: begin
                dec.opb_sel = OPB_IMM;
                dec.rd_wren = 1'b1;
                dec.jmp_en  = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_CHK_EN
                illegal = 1'b1;
`endif
            end
        endcase
`ifdef DECODE_ILLEGAL_CHK_EN
        // An illegal instruction must not have any architectural side effect.
        if (illegal) begin
            dec.rd_wren  = 1'b0;
            dec.mem_rden = 1'b0;
            dec.mem_wren = 1'b0;
            dec.br_en    = 1'b0;
            dec.jmp_en   = 1'b0;
        end
`endif
        if (dec.rd_addr == '0)
            dec.rd_wren = 1'b0;
    end

    // Skid-free handshake: a new word can enter whenever the slot is empty or
    // being drained this cycle. A flush drops whatever arrives alongside it.
    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready && !i_flush;

    // Pipeline register. Flush has priority over both capture and stall;
    // a stall simply leaves every register untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            bundle_q  <= '0;
            pc_q      <= '0;
`ifdef DECODE_ILLEGAL_CHK_EN
            illegal_q <= 1'b0;
`endif
        end else if (i_flush) begin
            valid_q   <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            bundle_q  <= dec;
            pc_q      <= i_pc;
`ifdef DECODE_ILLEGAL_CHK_EN
            illegal_q <= illegal;
`endif
        end else if (i_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign o_valid    = valid_q;
    assign o_pc       = pc_q;
    assign o_alu_op   = bundle_q.alu_op;
    assign o_opa_sel  = bundle_q.opa_sel;
    assign o_opb_sel  = bundle_q.opb_sel;
    assign o_imm      = bundle_q.imm;
    assign o_rs1_addr = bundle_q.rs1_addr;
    assign o_rs2_addr = bundle_q.rs2_addr;
    assign o_rd_addr  = bundle_q.rd_addr;
    assign o_rd_wren  = bundle_q.rd_wren;
    assign o_mem_rden = bundle_q.mem_rden;
    assign o_mem_wren = bundle_q.mem_wren;
    assign o_br_en    = bundle_q.br_en;
    assign o_jmp_en   = bundle_q.jmp_en;
`ifdef DECODE_ILLEGAL_CHK_EN
    assign o_illegal  = illegal_q;
`endif

endmodule
